// File: rtl/vga_sync_decoder.sv
// vga_sync_decoder: recovers raster position from a sampled hsync/vsync
// stream (640x480 timing by default), verifies the timing and reports lock,
// display window, frame start, timing errors and the measured line length.
// Optional build macro VGA_SYNC_DECODER_STATS_EN adds frame/error counters.
module vga_sync_decoder #(
  parameter int H_VISIBLE       = 640,
  parameter int H_FRONT         = 16,
  parameter int H_SYNC          = 96,
  parameter int H_BACK          = 48,
  parameter int V_VISIBLE       = 480,
  parameter int V_FRONT         = 10,
  parameter int V_SYNC          = 2,
  parameter int V_BACK          = 33,
  parameter int SYNC_ACTIVE_LOW = 1
) (
  input  logic       i_clock,
  input  logic       i_reset,
  input  logic       i_pixel_en,
  input  logic       i_hsync,
  input  logic       i_vsync,
  output logic [9:0] o_h_spot,
  output logic [9:0] o_v_spot,
  output logic       o_display_on,
  output logic       o_locked,
  output logic       o_frame_start,
  output logic       o_timing_err,
  output logic [9:0] o_line_len
`ifdef VGA_SYNC_DECODER_STATS_EN
  ,
  output logic [15:0] o_frame_count,
  output logic [7:0]  o_err_count
`endif
);

  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  localparam logic [9:0]  HS       = 10'(H_VISIBLE + H_FRONT);
  localparam logic [9:0]  VS       = 10'(V_VISIBLE + V_FRONT);
  localparam logic [9:0]  H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0]  V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0]  H_TOT10  = 10'(H_TOTAL);
  localparam logic [9:0]  H_SYNC10 = 10'(H_SYNC);
  localparam logic [9:0]  H_VIS10  = 10'(H_VISIBLE);
  localparam logic [9:0]  V_VIS10  = 10'(V_VISIBLE);
  // Missing hsync: nothing seen within one extra line (capped by saturation).
  localparam logic [9:0]  H_MISS   = 10'((2 * H_TOTAL < 1023) ? 2 * H_TOTAL : 1023);
  // Missing vsync: nothing seen within one extra frame.
  localparam logic [10:0] V_MISS   = 11'(2 * V_TOTAL);

  localparam logic [1:0] ST_SEARCH = 2'd0;
  localparam logic [1:0] ST_ALIGN  = 2'd1;
  localparam logic [1:0] ST_LOCKED = 2'd2;

  logic [1:0]  state_q, state_d;
  logic [9:0]  h_cnt_q, h_cnt_d;
  logic [9:0]  v_cnt_q, v_cnt_d;
  logic        hs_prev_q, hs_prev_d;
  logic        vs_prev_q, vs_prev_d;
  logic [9:0]  per_q, per_d;
  logic [9:0]  wid_q, wid_d;
  logic [10:0] lines_q, lines_d;
  logic [9:0]  line_len_q, line_len_d;
  logic        display_q, display_d;
  logic        frame_start_q, frame_start_d;
  logic        timing_err_q, timing_err_d;

  logic        hs_n, vs_n, hs_start, hs_end, vs_start;
  logic        h_wrap;
  logic [9:0]  h_free, v_free, per_inc, wid_inc, measured;
  logic [10:0] lines_inc;
  logic        hs_timeout, hs_stuck, vs_timeout;
  logic        align_err, locked_err;

  // Sync normalisation, edge detection and free-running counter arithmetic.
  always_comb begin
    hs_n      = (SYNC_ACTIVE_LOW != 0) ? ~i_hsync : i_hsync;
    vs_n      = (SYNC_ACTIVE_LOW != 0) ? ~i_vsync : i_vsync;
    hs_start  = hs_n & ~hs_prev_q;
    hs_end    = ~hs_n & hs_prev_q;
    vs_start  = vs_n & ~vs_prev_q;
    h_wrap    = (h_cnt_q == H_LAST);
    h_free    = h_wrap ? '0 : h_cnt_q + 10'd1;
    v_free    = h_wrap ? ((v_cnt_q == V_LAST) ? '0 : v_cnt_q + 10'd1) : v_cnt_q;
    per_inc   = (per_q == '1) ? per_q : per_q + 10'd1;
    wid_inc   = (wid_q == '1) ? wid_q : wid_q + 10'd1;
    lines_inc = (lines_q == '1) ? lines_q : lines_q + 11'd1;
    // Period in strobes including the current start strobe; 1023 saturates.
    measured  = per_inc;

    hs_timeout = !hs_start && (per_q >= H_MISS - 10'd1);
    hs_stuck   = hs_n && hs_prev_q && (wid_q >= H_TOT10);
    vs_timeout = !vs_start && (lines_q >= V_MISS);

    align_err = (hs_start && (measured != H_TOT10))
             || (hs_end && (wid_q != H_SYNC10))
             || hs_timeout || hs_stuck
             || (vs_start && !((h_free == '0) && (v_free == VS)))
             || (!vs_start && (h_free == '0) && (v_free == VS));

    locked_err = (hs_start && (h_cnt_q != HS - 10'd1))
              || (vs_start && (v_cnt_q != VS - 10'd1) && (v_cnt_q != VS))
              || hs_timeout || hs_stuck || vs_timeout;
  end

  // Next-state logic: everything holds unless a pixel strobe is present,
  // while the two pulse outputs fall back to zero on every clock.
  always_comb begin
    state_d       = state_q;
    h_cnt_d       = h_cnt_q;
    v_cnt_d       = v_cnt_q;
    hs_prev_d     = hs_prev_q;
    vs_prev_d     = vs_prev_q;
    per_d         = per_q;
    wid_d         = wid_q;
    lines_d       = lines_q;
    line_len_d    = line_len_q;
    display_d     = display_q;
    frame_start_d = 1'b0;
    timing_err_d  = 1'b0;

    if (i_pixel_en) begin
      hs_prev_d  = hs_n;
      vs_prev_d  = vs_n;
      h_cnt_d    = hs_start ? HS : h_free;
      v_cnt_d    = vs_start ? VS : v_free;
      per_d      = hs_start ? '0 : per_inc;
      wid_d      = hs_start ? 10'd1 : (hs_n ? wid_inc : wid_q);
      lines_d    = vs_start ? '0 : (h_wrap ? lines_inc : lines_q);
      line_len_d = hs_start ? measured : line_len_q;

      case (state_q)
        ST_SEARCH: begin
          if (vs_start) state_d = ST_ALIGN;
        end
        ST_ALIGN: begin
          if (align_err) begin
            state_d      = ST_SEARCH;
            timing_err_d = 1'b1;
          end else if (vs_start) begin
            state_d = ST_LOCKED;
          end
        end
        ST_LOCKED: begin
          if (locked_err) begin
            state_d      = ST_SEARCH;
            timing_err_d = 1'b1;
          end
        end
        default: state_d = ST_SEARCH;
      endcase

      display_d     = (state_d == ST_LOCKED) && (h_cnt_d < H_VIS10) && (v_cnt_d < V_VIS10);
      frame_start_d = (state_d == ST_LOCKED) && (h_cnt_d == '0) && (v_cnt_d == '0);
    end
  end

  // State register with synchronous reset.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state_q       <= ST_SEARCH;
      h_cnt_q       <= '0;
      v_cnt_q       <= '0;
      hs_prev_q     <= 1'b0;
      vs_prev_q     <= 1'b0;
      per_q         <= '0;
      wid_q         <= '0;
      lines_q       <= '0;
      line_len_q    <= '0;
      display_q     <= 1'b0;
      frame_start_q <= 1'b0;
      timing_err_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      h_cnt_q       <= h_cnt_d;
      v_cnt_q       <= v_cnt_d;
      hs_prev_q     <= hs_prev_d;
      vs_prev_q     <= vs_prev_d;
      per_q         <= per_d;
      wid_q         <= wid_d;
      lines_q       <= lines_d;
      line_len_q    <= line_len_d;
      display_q     <= display_d;
      frame_start_q <= frame_start_d;
      timing_err_q  <= timing_err_d;
    end
  end

  assign o_h_spot      = h_cnt_q;
  assign o_v_spot      = v_cnt_q;
  assign o_display_on  = display_q;
  assign o_locked      = (state_q == ST_LOCKED);
  assign o_frame_start = frame_start_q;
  assign o_timing_err  = timing_err_q;
  assign o_line_len    = line_len_q;

`ifdef VGA_SYNC_DECODER_STATS_EN
  logic [15:0] frame_count_q;
  logic [7:0]  err_count_q;

  // Statistics counters advance together with the pulses they count.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      frame_count_q <= '0;
      err_count_q   <= '0;
    end else begin
      if (frame_start_d) frame_count_q <= frame_count_q + 16'd1;
      if (timing_err_d && (err_count_q != '1)) err_count_q <= err_count_q + 8'd1;
    end
  end

  assign o_frame_count = frame_count_q;
  assign o_err_count   = err_count_q;
`endif

endmodule

// File: tb/tb_vga_sync_decoder.sv
// Directed bench for vga_sync_decoder using a reduced raster (32x20) so that
// several frames fit in a short run; one active-low and one active-high
// instance receive the same stream with opposite sync polarity.
module tb_vga_sync_decoder;

  localparam int HV = 16, HF = 4, HSW = 6, HB = 6;
  localparam int VV = 12, VF = 2, VSW = 2, VB = 4;
  localparam int HT = HV + HF + HSW + HB;   // 32
  localparam int VT = VV + VF + VSW + VB;   // 20
  localparam int HS = HV + HF;              // 20
  localparam int VS = VV + VF;              // 14

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, pen, hs_l, vs_l, hs_h, vs_h;
  logic [9:0] lo_h, lo_v, lo_len, hi_h, hi_v, hi_len;
  logic lo_disp, lo_lock, lo_fs, lo_err, hi_disp, hi_lock, hi_fs, hi_err;
`ifdef VGA_SYNC_DECODER_STATS_EN
  logic [15:0] lo_fc, hi_fc;
  logic [7:0]  lo_ec, hi_ec;
`endif

  vga_sync_decoder #(
    .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HSW), .H_BACK(HB),
    .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VSW), .V_BACK(VB),
    .SYNC_ACTIVE_LOW(1)
  ) u_lo (
    .i_clock(clk), .i_reset(rst), .i_pixel_en(pen), .i_hsync(hs_l), .i_vsync(vs_l),
    .o_h_spot(lo_h), .o_v_spot(lo_v), .o_display_on(lo_disp), .o_locked(lo_lock),
    .o_frame_start(lo_fs), .o_timing_err(lo_err), .o_line_len(lo_len)
`ifdef VGA_SYNC_DECODER_STATS_EN
    , .o_frame_count(lo_fc), .o_err_count(lo_ec)
`endif
  );

  vga_sync_decoder #(
    .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HSW), .H_BACK(HB),
    .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VSW), .V_BACK(VB),
    .SYNC_ACTIVE_LOW(0)
  ) u_hi (
    .i_clock(clk), .i_reset(rst), .i_pixel_en(pen), .i_hsync(hs_h), .i_vsync(vs_h),
    .o_h_spot(hi_h), .o_v_spot(hi_v), .o_display_on(hi_disp), .o_locked(hi_lock),
    .o_frame_start(hi_fs), .o_timing_err(hi_err), .o_line_len(hi_len)
`ifdef VGA_SYNC_DECODER_STATS_EN
    , .o_frame_count(hi_fc), .o_err_count(hi_ec)
`endif
  );

  int total = 0;
  int bad = 0;
  int gh = 0, gv = 0, fr = 0;
  bit track = 1'b0;
  bit glitch_arm = 1'b1;
  logic cap_err_lo, cap_err_hi, cap_fs_lo, cap_fs_hi;
  int fs_cnt_lo = 0, fs_cnt_hi = 0, err_cnt_lo = 0, err_cnt_hi = 0;
  int fs0_lo, fs0_hi;

  always @(posedge clk) begin
    if (lo_fs)  fs_cnt_lo  <= fs_cnt_lo + 1;
    if (hi_fs)  fs_cnt_hi  <= fs_cnt_hi + 1;
    if (lo_err) err_cnt_lo <= err_cnt_lo + 1;
    if (hi_err) err_cnt_hi <= err_cnt_hi + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One strobe of the reference raster at (gh,gv), then three idle clocks.
  task automatic step(input bit r);
    logic ha, va;
    ha = (gh >= HS) && (gh < HS + HSW);
    va = (gv >= VS) && (gv < VS + VSW);
    @(negedge clk);
    hs_l = ~ha; vs_l = ~va; hs_h = ha; vs_h = va;
    pen = 1'b1; rst = r;
    @(posedge clk); #1;
    pen = 1'b0; rst = 1'b0;
    cap_err_lo = lo_err; cap_err_hi = hi_err;
    cap_fs_lo  = lo_fs;  cap_fs_hi  = hi_fs;
    if (track) begin
      check("h_lo", lo_h, gh);
      check("v_lo", lo_v, gv);
      check("h_hi", hi_h, gh);
      check("v_hi", hi_v, gv);
      check("disp_lo", lo_disp, (gh < HV) && (gv < VV));
      check("disp_hi", hi_disp, (gh < HV) && (gv < VV));
      check("lock_lo", lo_lock, 1);
      check("lock_hi", hi_lock, 1);
      check("fs_lo", cap_fs_lo, (gh == 0) && (gv == 0));
      check("fs_hi", cap_fs_hi, (gh == 0) && (gv == 0));
      check("err_lo", cap_err_lo, 0);
      check("err_hi", cap_err_hi, 0);
    end
    repeat (3) @(posedge clk);
    #1;
    if (track) begin
      check("hold_h_lo", lo_h, gh);
      check("pulse_clr", {lo_fs, lo_err, hi_fs, hi_err}, 0);
    end
    // Shorten line 5 of frame 3 to HT-1 strobes.
    if (glitch_arm && fr == 3 && gv == 5 && gh == HT - 2) begin
      gh = HT - 1;
      glitch_arm = 1'b0;
    end
    gh++;
    if (gh == HT) begin
      gh = 0; gv++;
      if (gv == VT) begin gv = 0; fr++; end
    end
  endtask

  task automatic goto(input int f, input int v, input int h);
    int n;
    n = 0;
    while (!(fr == f && gv == v && gh == h) && n < 20000) begin
      step(1'b0);
      n++;
    end
    check("goto_reached", (n < 20000), 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; pen = 1'b0;
    hs_l = 1'b1; vs_l = 1'b1; hs_h = 1'b0; vs_h = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check("rst_pos_lo", {lo_h, lo_v}, 0);
    check("rst_flags_lo", {lo_disp, lo_lock, lo_fs, lo_err, lo_len}, 0);
    check("rst_pos_hi", {hi_h, hi_v}, 0);
    check("rst_flags_hi", {hi_disp, hi_lock, hi_fs, hi_err, hi_len}, 0);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    check("rel_lo", {lo_h, lo_v, lo_lock, lo_disp}, 0);
    check("rel_hi", {hi_h, hi_v, hi_lock, hi_disp}, 0);

    // Lock: vsync of frame 0 enters ALIGN, vsync of frame 1 locks.
    goto(1, VS - 1, HT - 1);
    step(1'b0);
    check("prelock_lo", lo_lock, 0);
    check("prelock_hi", hi_lock, 0);
    step(1'b0);
    check("lock_lo", lo_lock, 1);
    check("lock_hi", hi_lock, 1);
    check("lock_v_lo", lo_v, VS);
    check("lock_v_hi", hi_v, VS);
    check("lock_h_lo", lo_h, 0);

    // Tracking through frame 2 with display window corners.
    track = 1'b1;
    goto(2, 0, 1);
    fs0_lo = fs_cnt_lo; fs0_hi = fs_cnt_hi;
    goto(2, VV - 1, HV - 1);
    step(1'b0);
    check("win_in_lo", lo_disp, 1);
    check("win_in_hi", hi_disp, 1);
    step(1'b0);
    check("win_right_lo", lo_disp, 0);
    check("win_right_hi", hi_disp, 0);
    goto(2, VV, 0);
    step(1'b0);
    check("win_below_lo", lo_disp, 0);
    check("win_below_hi", hi_disp, 0);
    check("line_len_lo", lo_len, HT);
    check("line_len_hi", hi_len, HT);
    goto(3, 0, 1);
    check("fs_per_frame_lo", fs_cnt_lo - fs0_lo, 1);
    check("fs_per_frame_hi", fs_cnt_hi - fs0_hi, 1);
    track = 1'b0;

    // Glitch: short line 5 of frame 3 makes the line-6 hsync one strobe early.
    goto(3, 6, HS - 1);
    step(1'b0);
    check("preglitch_lock_lo", lo_lock, 1);
    check("preglitch_err_lo", cap_err_lo, 0);
    step(1'b0);
    check("glitch_err_lo", cap_err_lo, 1);
    check("glitch_err_hi", cap_err_hi, 1);
    check("glitch_unlock_lo", lo_lock, 0);
    check("glitch_unlock_hi", hi_lock, 0);

    // Relock after the next full valid frame.
    goto(4, VS - 1, HT - 1);
    step(1'b0);
    check("prerelock_lo", lo_lock, 0);
    step(1'b0);
    check("relock_lo", lo_lock, 1);
    check("relock_hi", hi_lock, 1);
    check("relock_v_lo", lo_v, VS);
    check("err_pulses_lo", err_cnt_lo, 1);
    check("err_pulses_hi", err_cnt_hi, 1);
`ifdef VGA_SYNC_DECODER_STATS_EN
    check("err_count_lo", lo_ec, 1);
    check("err_count_hi", hi_ec, 1);
`endif

    // Reset mid-operation at (10,8) of frame 5.
    goto(5, 8, 10);
    step(1'b1);
    check("midrst_lock_lo", lo_lock, 0);
    check("midrst_lock_hi", hi_lock, 0);
    check("midrst_h_lo", lo_h, 0);
    check("midrst_h_hi", hi_h, 0);
    check("midrst_all_lo", {lo_v, lo_disp, lo_fs, lo_err, lo_len}, 0);
`ifdef VGA_SYNC_DECODER_STATS_EN
    check("midrst_stats_lo", {lo_fc, lo_ec}, 0);
`endif
    goto(5, VS, 0);
    step(1'b0);
    check("restart_align_lo", lo_lock, 0);
    check("restart_align_hi", hi_lock, 0);
    goto(6, VS - 1, HT - 1);
    step(1'b0);
    check("restart_prelock_lo", lo_lock, 0);
    step(1'b0);
    check("restart_lock_lo", lo_lock, 1);
    check("restart_lock_hi", hi_lock, 1);
    check("restart_v_hi", hi_v, VS);
    check("restart_err_none", err_cnt_lo + err_cnt_hi, 2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
